// File: rtl/rtc_alarm_sched_if.sv
// Signal bundle between the alarm scheduler, the APB slot registers and the RTC alarm comparator.
interface rtc_alarm_sched_if #(
    parameter int NUM_SLOT = 4,
    parameter int CNT_W    = 32,
    parameter int IDX_W    = $clog2(NUM_SLOT)
);
    logic                cfg_we_i;
    logic [IDX_W-1:0]    cfg_idx_i;
    logic [CNT_W-1:0]    cfg_val_i;
    logic                cfg_en_i;
    logic [CNT_W-1:0]    cnt_i;
    logic [CNT_W-1:0]    alrm_val_o;
    logic                alrm_ld_o;
    logic                alrm_ack_i;
    logic                alrm_arm_o;
    logic                alrm_hit_i;
    logic [NUM_SLOT-1:0] irq_o;
    logic [NUM_SLOT-1:0] irq_clr_i;
    logic [IDX_W-1:0]    cur_idx_o;
    logic                busy_o;

    modport master (
        output cfg_we_i, cfg_idx_i, cfg_val_i, cfg_en_i, cnt_i,
               alrm_ack_i, alrm_hit_i, irq_clr_i,
        input  alrm_val_o, alrm_ld_o, alrm_arm_o, irq_o, cur_idx_o, busy_o
    );

    modport slave (
        input  cfg_we_i, cfg_idx_i, cfg_val_i, cfg_en_i, cnt_i,
               alrm_ack_i, alrm_hit_i, irq_clr_i,
        output alrm_val_o, alrm_ld_o, alrm_arm_o, irq_o, cur_idx_o, busy_o
    );
endinterface

// File: rtl/rtc_alarm_sched.sv
// Shares the single RTC alarm comparator among NUM_SLOT programmable alarm slots,
// always arming the enabled slot nearest in the future of the live RTC count.
module rtc_alarm_sched #(
    parameter int NUM_SLOT = 4,
    parameter int CNT_W    = 32,
    parameter int IDX_W    = $clog2(NUM_SLOT)
) (
    input logic              clk_i,
    input logic              rst_i,
    rtc_alarm_sched_if.slave bus
);
    // state | meaning
    // IDLE  | nothing armed; waits for a slot write or an enabled slot
    // SCAN  | walks slots 0..NUM_SLOT-1 looking for the nearest future alarm
    // LOAD  | presents the winner to the comparator until it acks
    // ARMED | comparator armed on cur_idx; waits for a hit or a slot rewrite
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_LOAD, S_ARMED} state_t;

    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_SLOT - 1);
    localparam logic [NUM_SLOT-1:0] SLOT_ONE = NUM_SLOT'(1);

    state_t              state;
    logic [CNT_W-1:0]    slot_val [NUM_SLOT];
    logic [NUM_SLOT-1:0] slot_en;
    logic                dirty;
    logic [IDX_W-1:0]    scan_ptr;
    logic [CNT_W-1:0]    cnt_q;
    logic                best_found;
    logic [IDX_W-1:0]    best_idx;
    logic [CNT_W-1:0]    best_dist;
    logic [CNT_W-1:0]    best_val;
    logic [CNT_W-1:0]    alrm_val_q;
    logic                alrm_ld_q;
    logic                alrm_arm_q;
    logic [NUM_SLOT-1:0] irq_q;
    logic [IDX_W-1:0]    cur_idx_q;

    logic [CNT_W-1:0]    cur_dist;
    logic                take_cur;
    logic                cfg_ok;
    logic                hit_svc;
    logic [NUM_SLOT-1:0] irq_set;

    // Modular distance makes a wrapped-around alarm look near, and strict '<' keeps the lowest index on ties.
    always_comb begin
        cur_dist = slot_val[scan_ptr] - cnt_q;
        take_cur = slot_en[scan_ptr] && (!best_found || (cur_dist < best_dist));
        cfg_ok   = {1'b0, bus.cfg_idx_i} < (IDX_W + 1)'(NUM_SLOT);
        hit_svc  = (state == S_ARMED) && bus.alrm_hit_i;
        irq_set  = hit_svc ? (SLOT_ONE << cur_idx_q) : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            for (int i = 0; i < NUM_SLOT; i++) slot_val[i] <= '0;
            slot_en    <= '0;
            dirty      <= 1'b0;
            scan_ptr   <= '0;
            cnt_q      <= '0;
            best_found <= 1'b0;
            best_idx   <= '0;
            best_dist  <= '0;
            best_val   <= '0;
            alrm_val_q <= '0;
            alrm_ld_q  <= 1'b0;
            alrm_arm_q <= 1'b0;
            irq_q      <= '0;
            cur_idx_q  <= '0;
        end else begin
            irq_q <= (irq_q & ~bus.irq_clr_i) | irq_set;
            case (state)
                S_IDLE: begin
                    if (dirty || (|slot_en)) begin
                        state      <= S_SCAN;
                        scan_ptr   <= '0;
                        cnt_q      <= bus.cnt_i;
                        best_found <= 1'b0;
                        dirty      <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (take_cur) begin
                        best_found <= 1'b1;
                        best_idx   <= scan_ptr;
                        best_dist  <= cur_dist;
                        best_val   <= slot_val[scan_ptr];
                    end
                    if (scan_ptr == LAST_IDX) begin
                        if (take_cur || best_found) begin
                            state      <= S_LOAD;
                            alrm_ld_q  <= 1'b1;
                            alrm_val_q <= take_cur ? slot_val[scan_ptr] : best_val;
                            cur_idx_q  <= take_cur ? scan_ptr : best_idx;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        scan_ptr <= scan_ptr + 1'b1;
                    end
                end
                S_LOAD: begin
                    if (bus.alrm_ack_i) begin
                        alrm_ld_q  <= 1'b0;
                        alrm_arm_q <= 1'b1;
                        state      <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (hit_svc || dirty) begin
                        if (hit_svc) slot_en[cur_idx_q] <= 1'b0;
                        alrm_arm_q <= 1'b0;
                        state      <= S_SCAN;
                        scan_ptr   <= '0;
                        cnt_q      <= bus.cnt_i;
                        best_found <= 1'b0;
                        dirty      <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
            // Placed after the FSM so a write beats a one-shot disable and re-marks dirty on scan entry.
            if (bus.cfg_we_i && cfg_ok) begin
                slot_val[bus.cfg_idx_i] <= bus.cfg_val_i;
                slot_en[bus.cfg_idx_i]  <= bus.cfg_en_i;
                dirty                   <= 1'b1;
            end
        end
    end

    assign bus.alrm_val_o = alrm_val_q;
    assign bus.alrm_ld_o  = alrm_ld_q;
    assign bus.alrm_arm_o = alrm_arm_q;
    assign bus.irq_o      = irq_q;
    assign bus.cur_idx_o  = cur_idx_q;
    assign bus.busy_o     = (state == S_SCAN) || (state == S_LOAD);
endmodule

// File: doc/rtc_alarm_sched.md
Name: rtc_alarm_sched

Overview:
Scheduler that shares the RTC's single hardware alarm comparator among NUM_SLOT software-programmed alarm slots. It scans the enabled slots and finds the one nearest in the future relative to the live RTC count. It loads that slot's value into the comparator via a load handshake, and on a comparator hit raises that slot's interrupt and reschedules. It sits between the APB register file (slot programming) and the RTC core's alarm comparator; all signals are in the APB clock domain, and the RTC count arrives already synchronised.

Parameters:
NUM_SLOT, 4, number of alarm slots (2..16)
CNT_W, 32, width of RTC count and alarm values
IDX_W, $clog2(NUM_SLOT), slot index width

Ports:
clk_i  input  1  APB-domain clock
rst_i  input  1  synchronous reset, active-high
cfg_we_i  input  1  slot write strobe, one cycle
cfg_idx_i  input  IDX_W  slot being written
cfg_val_i  input  CNT_W  alarm value for the slot
cfg_en_i  input  1  enable bit written with the value (0 = disable slot)
cnt_i  input  CNT_W  current RTC count, synchronised
alrm_val_o  output  CNT_W  value presented to the RTC alarm comparator
alrm_ld_o  output  1  load request to the comparator
alrm_ack_i  input  1  comparator accepted alrm_val_o
alrm_arm_o  output  1  comparator is armed with a valid slot
alrm_hit_i  input  1  one-cycle pulse: count == armed value
irq_o  output  NUM_SLOT  per-slot sticky interrupt
irq_clr_i  input  NUM_SLOT  per-slot write-1-to-clear
cur_idx_o  output  IDX_W  slot currently armed
busy_o  output  1  high in SCAN/LOAD

Behaviour:
- Reset (rst_i sampled high at posedge): all slot values 0, enables 0, irq_o 0, alrm_val_o 0, alrm_ld_o 0, alrm_arm_o 0, cur_idx_o 0, busy_o 0, dirty 0, FSM=IDLE. Reset mid-handshake drops alrm_ld_o on the next edge; the comparator must ignore a stale ack.
- Slot write: on cfg_we_i, slot[cfg_idx_i] takes {cfg_en_i, cfg_val_i} at the next edge and the dirty flag is set. Writes are accepted in every state. cfg_idx_i >= NUM_SLOT is ignored and does not set dirty.
- Distance: dist = (slot_val - cnt_i) mod 2^CNT_W, unsigned. A value equal to cnt_i has distance 0 and is the earliest. Wrap-around is handled by the modular subtraction.
- FSM states:
  - IDLE: alrm_arm_o=0. Goes to SCAN when dirty=1 or any slot is enabled.
  - SCAN: one slot per cycle, index 0..NUM_SLOT-1, so it takes NUM_SLOT cycles. It clears dirty on entry and tracks the minimum distance among enabled slots. Ties go to the lowest index. At the end it goes to LOAD if any slot is enabled, otherwise to IDLE. cnt_i is sampled once on SCAN entry and held for the whole scan. A write during SCAN sets dirty again.
  - LOAD: alrm_val_o = winner value, cur_idx_o = winner, alrm_ld_o=1. alrm_ld_o and alrm_val_o are held stable until alrm_ack_i. On ack: alrm_ld_o=0 and alrm_arm_o=1 at the next edge, then go to ARMED. An ack in the same cycle as alrm_ld_o rising is legal.
  - ARMED: on alrm_hit_i, set irq_o[cur_idx_o], clear the enable of that slot (one-shot), alrm_arm_o=0, go to SCAN. Otherwise, if dirty=1, alrm_arm_o=0 and go to SCAN.
- Simultaneous events in ARMED:
  - alrm_hit_i and a cfg write in the same cycle: the hit is serviced first (irq set, slot disabled), then the write is applied and dirty set. If the write targets the hit slot, the write wins for value and enable; the irq is still set.
  - irq_clr_i[k] in the same cycle as an irq set for k: the set wins.
- alrm_hit_i outside ARMED is ignored.
- busy_o = (state==SCAN || state==LOAD).
- Latency: from a write in IDLE to alrm_ld_o is 1 (IDLE→SCAN) + NUM_SLOT (SCAN) cycles.

Test Plan:
1. Reset, then write slot2 = 100 with enable (cnt_i = 10) → after 1+4 cycles alrm_ld_o=1, alrm_val_o=100, cur_idx_o=2; ack → alrm_arm_o=1.
2. Slots 0=500, 1=200, 3=200 enabled, cnt_i=50 → slot1 is armed (tie with slot3 goes to lowest index). Hit pulse → irq_o=4'b0010, slot1 disabled, rescan arms slot3 with value 200.
3. Wrap: cnt_i=32'hFFFF_FFF0, slot0=32'h0000_0010, slot1=32'hFFFF_FFF8 → slot1 is armed (distance 8 vs 32).
4. While armed on slot0=300, write slot1=150 with enable → alrm_arm_o drops, rescan, slot1 is loaded with 150. Disabling all slots → FSM returns to IDLE with alrm_arm_o=0.
5. Hit and a write to the same slot (new value 900, enable) in one cycle → irq set, slot keeps the 900 value and stays enabled, and is rearmed. irq_clr_i in the same cycle as a set → irq stays 1.
6. Assert rst_i during LOAD with ack withheld → next cycle alrm_ld_o=0, all irq_o=0, FSM=IDLE, all slots disabled.
